// File: rtl/scroll_layer_ctrl_pkg.sv
// Shared definitions for the layer scroll controller: FSM encodings, per-row
// resting positions and the ypos helper.
package scroll_layer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SCROLL = 2'b01,
        ST_END    = 2'b10
    } scroll_state_t;

    // Resting y position of each of the five layer rows, in pixels.
    localparam int ROW0_Y_BASE = 25;
    localparam int ROW1_Y_BASE = 175;
    localparam int ROW2_Y_BASE = 325;
    localparam int ROW3_Y_BASE = 475;
    localparam int ROW4_Y_BASE = 625;

    localparam int SHIFT_W = 8;
    localparam int YPOS_W  = 12;

    function automatic logic [YPOS_W-1:0] ypos_of(input int base, input logic [SHIFT_W-1:0] shift);
        return YPOS_W'(base) + YPOS_W'(shift);
    endfunction

endpackage

// File: rtl/scroll_layer_ctrl_step_counter.sv
// Scroll distance accumulator: holds the current shift and the per-tick step,
// and flags the tick that reaches (or would pass) the scroll distance.
module scroll_step_counter
    import scroll_layer_ctrl_pkg::*;
#(
    parameter int SCROLL_DIST = 150,
    parameter int SPD_W       = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic [SPD_W-1:0]   speed,
    input  logic               advance,
    input  logic               clear,
    output logic [SHIFT_W-1:0] shift,
    output logic               reached_end
);

    logic [SPD_W-1:0] step;
    logic [8:0]       sum;

    // Nine-bit sum so a large step near the end saturates instead of wrapping.
    assign sum         = {1'b0, shift} + 9'(step);
    assign reached_end = advance && (sum >= 9'(SCROLL_DIST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
            step  <= SPD_W'(1);
        end else if (arm) begin
            shift <= '0;
            step  <= (speed == '0) ? SPD_W'(1) : speed;
        end else if (clear) begin
            shift <= '0;
        end else if (reached_end) begin
            shift <= SHIFT_W'(SCROLL_DIST);
        end else if (advance) begin
            shift <= sum[SHIFT_W-1:0];
        end
    end

endmodule

// File: rtl/scroll_layer_ctrl.sv
// Per-layer scroll controller: latches the layer maps and scrolls the layer
// down by SCROLL_DIST pixels. Define SCROLL_PAUSE_EN to add the pause input.
module scroll_layer_ctrl
    import scroll_layer_ctrl_pkg::*;
#(
    parameter int BLOCKS      = 7,
    parameter int Y_BASE      = 25,
    parameter int SCROLL_DIST = 150,
    parameter int SPD_W       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                module_en,
    input  logic                tick,
    input  logic                start,
    input  logic                load,
    input  logic [SPD_W-1:0]    speed,
    input  logic [0:BLOCKS-1]   layer_map_in,
    input  logic [0:BLOCKS-1]   block_type_in,
    input  logic [0:BLOCKS-1]   bonus_map_in,
`ifdef SCROLL_PAUSE_EN
    input  logic                pause,
`endif
    output logic [0:BLOCKS-1]   layer_map_out,
    output logic [0:BLOCKS-1]   block_type_out,
    output logic [0:BLOCKS-1]   bonus_map_out,
    output logic [YPOS_W-1:0]   ypos,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_dbg
);

    localparam int MW = 3 * BLOCKS;

    scroll_state_t      state_q, state_d;
    logic [MW-1:0]      live_maps, out_q, shadow_q;
    logic               pending_q;
    logic [SHIFT_W-1:0] shift;
    logic               reached_end;
    logic               arm, advance, hold;

`ifdef SCROLL_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign live_maps = {layer_map_in, block_type_in, bonus_map_in};

    // A start that coincides with a load in IDLE is dropped.
    assign arm     = (state_q == ST_IDLE) && !load && start;
    assign advance = (state_q == ST_SCROLL) && tick && module_en && !hold;

    scroll_step_counter #(
        .SCROLL_DIST (SCROLL_DIST),
        .SPD_W       (SPD_W)
    ) u_step (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm         (arm),
        .speed       (speed),
        .advance     (advance),
        .clear       (state_q == ST_END),
        .shift       (shift),
        .reached_end (reached_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!load && start) state_d = ST_SCROLL;
            ST_SCROLL: if (reached_end)    state_d = ST_END;
            ST_END:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) out_q <= live_maps;
                end
                ST_SCROLL: begin
                    // Visible maps stay frozen mid-scroll; the last load wins.
                    if (load) begin
                        shadow_q  <= live_maps;
                        pending_q <= 1'b1;
                    end
                end
                ST_END: begin
                    pending_q <= 1'b0;
                    if (load || !pending_q) out_q <= live_maps;
                    else                    out_q <= shadow_q;
                end
                default: ;
            endcase
        end
    end

    assign layer_map_out  = out_q[MW-1 -: BLOCKS];
    assign block_type_out = out_q[2*BLOCKS-1 -: BLOCKS];
    assign bonus_map_out  = out_q[BLOCKS-1:0];

    assign ypos      = ypos_of(Y_BASE, shift);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_END);
    assign state_dbg = state_q;

endmodule

// File: doc/scroll_layer_ctrl.md
Name: scroll_layer_ctrl

Overview:
- Parametrised successor of the per-layer scroll controller.
- Latches one layer's block/type/bonus maps and scrolls the layer down by a programmable distance at a programmable speed.
- Presents the current vertical draw position (ypos) to the layer renderer. The renderer, its ROMs and the VGA bus path stay outside this block.
- Adds: variable speed, deferred load during a scroll, busy/done status, and an optional pause.

Parameters:
- BLOCKS, 7: blocks per layer; width of every map bus.
- Y_BASE, 25: resting y position of this layer, in pixels.
- SCROLL_DIST, 150: pixels scrolled per start, range 1..255.
- SPD_W, 3: width of the speed input.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- module_en  in  1  when 0, ticks are ignored (scroll freezes)
- tick  in  1  one-cycle 1 ms strobe
- start  in  1  begin a scroll (pulse)
- load  in  1  capture input maps (pulse)
- speed  in  SPD_W  pixels per tick; sampled at start
- layer_map_in  in  [0:BLOCKS-1]  new layer map
- block_type_in  in  [0:BLOCKS-1]  new block types
- bonus_map_in  in  [0:BLOCKS-1]  new bonus map
- pause  in  1  freeze scroll (present only with SCROLL_PAUSE_EN)
- layer_map_out  out  [0:BLOCKS-1]  active layer map
- block_type_out  out  [0:BLOCKS-1]  active block types
- bonus_map_out  out  [0:BLOCKS-1]  active bonus map
- ypos  out  12  Y_BASE + shift, combinational from registers
- busy  out  1  high in SCROLL and END states
- done  out  1  one-cycle pulse at scroll completion

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; shift=0; step=1.
  - All map outputs, shadow maps and pending = 0.
  - busy=0, done=0, ypos=Y_BASE.
- Registers: shift is 8 bits, step is SPD_W bits. ypos is the 12-bit zero-extended sum of Y_BASE and shift.
- IDLE:
  - load=1: next cycle, outputs = inputs. Load has priority over a same-cycle start; that start is dropped.
  - else start=1: shift <= 0; step <= speed (speed 0 is treated as 1); go to SCROLL.
- SCROLL:
  - On tick & module_en: if shift + step >= SCROLL_DIST, then shift <= SCROLL_DIST and go to END. Otherwise shift <= shift + step.
  - The compare is done at 9 bits, so there is no wrap.
  - start is ignored.
  - load=1: inputs are captured into the shadow registers and pending <= 1. A later load overwrites the shadow (last load wins).
  - Output maps do not change during SCROLL.
- END (exactly one cycle):
  - done=1, busy=1.
  - shift <= 0.
  - Outputs <= shadow if pending, else the live inputs; pending <= 0.
  - Go to IDLE.
  - load in this cycle behaves as an IDLE load applied on the next cycle and overrides the END transfer.
- Timing: with speed=1, exactly SCROLL_DIST accepted ticks from start to END. ypos returns to Y_BASE the cycle after END.
- done is registered, high only while state==END. busy = (state != IDLE).
- Undefined state encodings go to IDLE.

Optional Feature:
- Macro: SCROLL_PAUSE_EN.
- Defined: the pause port exists. While pause=1 in SCROLL, ticks are ignored; load capture into the shadow still works.
- Not defined: no pause port; scroll advances on every tick & module_en.

Decomposition:
- Shared macros header (existing `include "macros.vh"` style):
  - SCROLL state encodings (IDLE=2'b00, SCROLL=2'b01, END=2'b10).
  - Per-row Y_BASE constants: 25, 175, 325, 475, 625.
- One natural sub-module, scroll_step_counter:
  - Contains shift, step, and the saturation compare.
  - Produces a reached_end flag.
- Map latches and shadow registers stay in the top module.

Test Plan:
- Reset mid-scroll: start with speed=1, after 40 ticks pull rst_n low without a clock edge -> state IDLE, ypos=25, all maps 0 immediately.
- Basic scroll: load 7'b1010101, then start with speed=1 and 150 ticks -> ypos steps 25..175; done pulses once after tick 150; ypos=25 the next cycle; busy low after.
- Speed saturation: SCROLL_DIST=150, speed=4 -> shift runs 0,4,...,148, then 150 at the 38th tick; END; no overshoot past ypos=175.
- Deferred load: during SCROLL, load A then B -> outputs unchanged until END; after END outputs=B; pending clear.
- Simultaneous load+start in IDLE -> maps latched, state remains IDLE. module_en=0 with 10 ticks in SCROLL -> shift unchanged.
- SCROLL_PAUSE_EN build: pause=1 for 20 ticks at shift=60 -> shift holds 60; resumes on release; total accepted ticks = 150.
